md_unit_ctrl: RTL and testbench

- Multiply/divide sequencer for the E stage of the MIPS pipeline.
- Accepts the E-stage MD_op/start decode and two 32-bit operands, and owns the HI/LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Produces the D-stage stall request used by the hazard unit for instructions that touch HI/LO.

---
 rtl/md_unit_ctrl.sv | 129 ++++++++++++
 tb/tb_md_unit_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit_ctrl
//  Purpose  : E-stage multiply/divide sequencer owning HI/LO, with a latency
//             counter and the D-stage stall request for HI/LO users.
//  Revision : 1.0  initial release
// ============================================================================
module md_unit_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MD_op,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_den;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_cmd_ok;
    logic        w_div_zero;

    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Divide by magnitudes so that 0x80000000 / -1 cannot overflow; a zero
    // divisor is replaced by 1 only to keep the divider defined, its result
    // is never committed.
    assign w_div_zero = (B == 32'd0);
    assign w_den      = w_div_zero ? 32'd1 : B;
    assign w_abs_a    = A[31] ? (~A + 32'd1) : A;
    assign w_abs_b    = w_den[31] ? (~w_den + 32'd1) : w_den;
    assign w_sq_mag   = w_abs_a / w_abs_b;
    assign w_sr_mag   = w_abs_a % w_abs_b;
    assign w_sq       = (A[31] ^ w_den[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr       = A[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
    assign w_uq       = A / w_den;
    assign w_ur       = A % w_den;

    assign w_cmd_ok = !cancel && (r_state == c_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_cmd_ok) begin
                        case (MD_op)
                            3'd1, 3'd3: if (start) begin
                                {r_pend_hi, r_pend_lo} <= (MD_op == 3'd3) ? w_prod_s : w_prod_u;
                                r_pend_wr <= 1'b1;
                                r_cnt     <= c_CNT_W'(MULT_LAT);
                                r_state   <= c_BUSY;
                            end
                            3'd2, 3'd4: if (start) begin
                                r_pend_hi <= (MD_op == 3'd4) ? w_sr : w_ur;
                                r_pend_lo <= (MD_op == 3'd4) ? w_sq : w_uq;
                                r_pend_wr <= !w_div_zero;
                                r_cnt     <= c_CNT_W'(DIV_LAT);
                                r_state   <= c_BUSY;
                            end
                            3'd5:    r_hi <= A;
                            3'd6:    r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                c_BUSY: begin
                    // Commands and cancel are deliberately ignored here: the
                    // in-flight op belongs to an already committed instruction.
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == c_BUSY);
    assign md_stall = md_use_D && (busy || start);
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit_ctrl
//  Purpose  : Self-checking bench for md_unit_ctrl against a cycle-indexed
//             reference model of HI/LO and completion time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit_ctrl;

    localparam int c_MULT_LAT = 5;
    localparam int c_DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MD_op;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        md_use_D;
    wire         busy;
    wire         md_stall;
    wire  [31:0] HI;
    wire  [31:0] LO;

    int total = 0;
    int bad   = 0;

    md_unit_ctrl #(.MULT_LAT(c_MULT_LAT), .DIV_LAT(c_DIV_LAT)) dut (
        .clk(clk), .reset(reset), .MD_op(MD_op), .start(start), .A(A), .B(B),
        .cancel(cancel), .md_use_D(md_use_D), .busy(busy), .md_stall(md_stall),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Model: edge counter, the edge at which the current op finishes, and
    // the result it will commit at that edge.
    longint      m_cycle = 0;
    longint      m_fin   = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [31:0] m_phi   = '0;
    logic [31:0] m_plo   = '0;
    bit          m_pwr   = 1'b0;

    function automatic bit m_busy();
        return m_cycle < m_fin;
    endfunction

    function automatic bit m_stall();
        return md_use_D && (m_busy() || start);
    endfunction

    task automatic cyc();
        longint e = m_cycle + 1;
        longint sa, sb, q, r;
        longint unsigned pu;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_fin = 0; m_pwr = 1'b0;
        end else if (e == m_fin) begin
            if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (!m_busy() && !cancel) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            case (MD_op)
                3'd1: if (start) begin
                    pu = longint'(A) * longint'(B);
                    {m_phi, m_plo} = pu; m_pwr = 1'b1; m_fin = e + c_MULT_LAT;
                end
                3'd3: if (start) begin
                    q = sa * sb;
                    {m_phi, m_plo} = q; m_pwr = 1'b1; m_fin = e + c_MULT_LAT;
                end
                3'd2: if (start) begin
                    m_pwr = (B != 0);
                    if (m_pwr) begin m_plo = A / B; m_phi = A % B; end
                    m_fin = e + c_DIV_LAT;
                end
                3'd4: if (start) begin
                    m_pwr = (B != 0);
                    if (m_pwr) begin
                        q = sa / sb; r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                    m_fin = e + c_DIV_LAT;
                end
                3'd5: m_hi = A;
                3'd6: m_lo = A;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_cycle = e;
    endtask

    task automatic idle_in();
        MD_op = 3'd0; start = 1'b0; A = '0; B = '0; cancel = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MD_op = op; A = a; B = b;
        start = (op >= 3'd1 && op <= 3'd4);
    endtask

    task automatic test_reset();
        reset = 1'b1; md_use_D = 1'b1; idle_in();
        cyc(); cyc();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", LO); end
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", md_stall); end
        md_use_D = 1'b0;
    endtask

    task automatic test_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit use_d, input int lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        md_use_D = use_d;
        issue(op, a, b);
        #1;
        total++; if (md_stall !== use_d) begin bad++; $display("FAIL %s start_stall got=%b want=%b", nm, md_stall, use_d); end
        cyc();
        idle_in();
        while (busy === 1'b1 && n < 40) begin
            #1;
            total++; if (md_stall !== m_stall()) begin bad++; $display("FAIL %s busy_stall got=%b want=%b", nm, md_stall, m_stall()); end
            n++;
            cyc();
        end
        total++; if (n !== lat) begin bad++; $display("FAIL %s busy_len got=%0d want=%0d", nm, n, lat); end
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL %s after_stall got=%b want=0", nm, md_stall); end
        total++; if (HI !== exp_hi || HI !== m_hi) begin bad++; $display("FAIL %s hi got=%h want=%h model=%h", nm, HI, exp_hi, m_hi); end
        total++; if (LO !== exp_lo || LO !== m_lo) begin bad++; $display("FAIL %s lo got=%h want=%h model=%h", nm, LO, exp_lo, m_lo); end
        md_use_D = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd5, 32'hDEADBEEF, '0);
        cyc(); idle_in();
        total++; if (HI !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi got=%h want=deadbeef", HI); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", busy); end
        issue(3'd5, 32'h0BADF00D, '0); cancel = 1'b1;
        cyc(); idle_in();
        total++; if (HI !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi_cancel got=%h want=deadbeef", HI); end
        issue(3'd3, 32'd9, 32'd9); cancel = 1'b1;
        cyc(); idle_in();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_cancel busy got=%b want=0", busy); end
        issue(3'd6, 32'h5678, '0); cyc();
        issue(3'd5, 32'h1234, '0); cyc(); idle_in();
        total++; if (HI !== 32'h1234 || LO !== 32'h5678) begin bad++; $display("FAIL mthi_mtlo got=%h/%h want=1234/5678", HI, LO); end
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        issue(3'd2, 32'd100, 32'd7);
        cyc(); idle_in();
        for (int i = 0; i < 12 && busy === 1'b1; i++) begin
            case (i)
                1: issue(3'd3, 32'd3, 32'd3);
                3: issue(3'd6, 32'hCAFE, '0);
                5: cancel = 1'b1;
                6: issue(3'd1, 32'd5, 32'd5);
                default: idle_in();
            endcase
            n++;
            cyc();
            idle_in();
        end
        total++; if (n !== c_DIV_LAT) begin bad++; $display("FAIL ignore_len got=%0d want=%0d", n, c_DIV_LAT); end
        total++; if (HI !== 32'd2 || LO !== 32'd14) begin bad++; $display("FAIL ignore_result got=%h/%h want=2/e", HI, LO); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int late = 0;
        issue(3'd3, 32'd1000, 32'd1000);
        cyc(); idle_in();
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++; $display("FAIL reset_mid got=%b/%h/%h want=0/0/0", busy, HI, LO);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) late++;
        end
        total++; if (late !== 0) begin bad++; $display("FAIL reset_late_write got=%0d want=0", late); end
    endtask

    task automatic test_random();
        logic [31:0] pool_a [4];
        logic [31:0] pool_b [4];
        logic [2:0]  op;
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            pool_a[0] = 32'h80000000; pool_a[1] = 32'hFFFFFFFF; pool_a[2] = $urandom_range(0, 50); pool_a[3] = $urandom;
            pool_b[0] = 32'hFFFFFFFF; pool_b[1] = 32'd0; pool_b[2] = $urandom_range(1, 9) | {$urandom_range(0, 1), 31'd0}; pool_b[3] = $urandom;
            op = 3'($urandom_range(0, 7));
            MD_op    = op;
            start    = (op >= 3'd1 && op <= 3'd4) && ($urandom_range(0, 2) != 0);
            A        = pool_a[$urandom_range(0, 3)];
            B        = pool_b[$urandom_range(0, 3)];
            cancel   = ($urandom_range(0, 7) == 0);
            md_use_D = $urandom_range(0, 1);
            #1;
            total++; if (md_stall !== m_stall()) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_stall i=%0d got=%b want=%b", i, md_stall, m_stall()); end
            cyc();
            total++; if (busy !== m_busy() || HI !== m_hi || LO !== m_lo) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_state i=%0d got=%b/%h/%h want=%b/%h/%h", i, busy, HI, LO, m_busy(), m_hi, m_lo);
            end
        end
        idle_in(); md_use_D = 1'b0;
    endtask

    initial begin
        test_reset();
        test_op("mult",  3'd3, 32'hFFFFFFFF, 32'd2, 1'b1, c_MULT_LAT, 32'hFFFFFFFF, 32'hFFFFFFFE);
        test_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, c_MULT_LAT, 32'h00000001, 32'hFFFFFFFE);
        test_op("div",   3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, c_DIV_LAT,  32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("divov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, c_DIV_LAT, 32'h00000000, 32'h80000000);
        test_mthi_mtlo();
        test_op("divu0", 3'd2, 32'd7, 32'd0, 1'b1, c_DIV_LAT, 32'h1234, 32'h5678);
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
